// File: rtl/bmu_rr_scheduler.sv
// bmu_rr_scheduler
//   Shares a single BMU between NUM_REQ requesters. Round-robin grant over
//   valid/ready request ports, combinational drive of the BMU inputs from the
//   granted request, one-cycle in-flight tracking through the BMU output
//   register, and a RSP_DEPTH-entry response FIFO back to the requesters.
//   An issue credit is consumed by the in-flight op and by every queued entry,
//   so the FIFO can never overflow.
//   Optional feature: define BMU_SCHED_ERRCNT_EN to add err_clr/err_count,
//   a saturating count of popped responses that carry the BMU error flag.
module bmu_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int OP_W      = 23,
  parameter int RSP_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*32-1:0]      req_b,
  input  logic [NUM_REQ*OP_W-1:0]    req_op,
  output logic                       bmu_valid_in,
  output logic [31:0]                bmu_a_in,
  output logic [31:0]                bmu_b_in,
  output logic [OP_W-1:0]            bmu_ap,
  input  logic [31:0]                bmu_result,
  input  logic                       bmu_error,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_result,
  output logic                       rsp_error
`ifdef BMU_SCHED_ERRCNT_EN
  ,
  input  logic                       err_clr,
  output logic [15:0]                err_count
`endif
);

  localparam int          IDW         = $clog2(NUM_REQ);
  localparam int          PTRW        = $clog2(RSP_DEPTH);
  localparam int          CNTW        = $clog2(RSP_DEPTH + 1);
  localparam int unsigned NUM_REQ_U   = NUM_REQ;
  localparam int unsigned RSP_DEPTH_U = RSP_DEPTH;

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            inflight_vld_q, inflight_vld_d;
  logic [IDW-1:0]  inflight_id_q, inflight_id_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic [IDW-1:0]  q_id_q  [RSP_DEPTH];
  logic [31:0]     q_res_q [RSP_DEPTH];
  logic            q_err_q [RSP_DEPTH];

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic            can_issue;
  logic            grant;
  logic            push;
  logic            pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ_U; off++) begin
      cand = IDW'((32'(rr_ptr_q) + off) % NUM_REQ_U);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Credit check: a pop in this same cycle does not return a credit.
  always_comb begin
    can_issue = (32'(count_q) + 32'(inflight_vld_q)) < RSP_DEPTH_U;
    grant     = gnt_found & can_issue;
    push      = inflight_vld_q;
    pop       = rsp_valid & rsp_ready;
  end

  // Handshake and BMU operand mux from the granted requester.
  always_comb begin
    req_ready    = '0;
    bmu_valid_in = grant;
    bmu_a_in     = '0;
    bmu_b_in     = '0;
    bmu_ap       = '0;
    for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
      if (grant && (gnt_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        bmu_a_in     = req_a[32*i +: 32];
        bmu_b_in     = req_b[32*i +: 32];
        bmu_ap       = req_op[OP_W*i +: OP_W];
      end
    end
  end

  // Next-state for arbitration pointer, in-flight tracker and FIFO control.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    inflight_vld_d = grant;
    inflight_id_d  = inflight_id_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    if (grant) begin
      rr_ptr_d      = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      inflight_id_d = gnt_idx;
    end
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO head drives the response port; fields read zero when empty.
  always_comb begin
    rsp_valid  = (count_q != '0);
    rsp_id     = rsp_valid ? q_id_q[rd_ptr_q]  : '0;
    rsp_result = rsp_valid ? q_res_q[rd_ptr_q] : '0;
    rsp_error  = rsp_valid ? q_err_q[rd_ptr_q] : 1'b0;
  end

  // Control state registers; reset discards the in-flight op and the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      inflight_vld_q <= 1'b0;
      inflight_id_q  <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      inflight_vld_q <= inflight_vld_d;
      inflight_id_q  <= inflight_id_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // FIFO storage: capture the BMU output the cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RSP_DEPTH_U; i++) begin
        q_id_q[i]  <= '0;
        q_res_q[i] <= '0;
        q_err_q[i] <= 1'b0;
      end
    end else if (push) begin
      q_id_q[wr_ptr_q]  <= inflight_id_q;
      q_res_q[wr_ptr_q] <= bmu_result;
      q_err_q[wr_ptr_q] <= bmu_error;
    end
  end

`ifdef BMU_SCHED_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Saturating error counter; a clear takes priority over an increment.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (pop && rsp_error && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_bmu_rr_scheduler.sv
// Directed bench for bmu_rr_scheduler with a behavioural one-cycle BMU.
// Table-driven per-cycle vectors cover round-robin order, credit stalls and
// back-pressure; hand sequences cover single ops, error results, the optional
// error counter (BMU_SCHED_ERRCNT_EN) and reset in the middle of traffic.
module tb_bmu_rr_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int OP_W      = 23;
  localparam int RSP_DEPTH = 2;
  localparam logic [OP_W-1:0] OP_ADD  = 23'h000001;
  localparam logic [OP_W-1:0] OP_GORC = 23'h000002;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_a;
  logic [NUM_REQ*32-1:0]   req_b;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic                    bmu_valid_in;
  logic [31:0]             bmu_a_in;
  logic [31:0]             bmu_b_in;
  logic [OP_W-1:0]         bmu_ap;
  logic [31:0]             bmu_result;
  logic                    bmu_error;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [31:0]             rsp_result;
  logic                    rsp_error;
`ifdef BMU_SCHED_ERRCNT_EN
  logic                    err_clr;
  logic [15:0]             err_count;
`endif

  int errors = 0;
  int checks = 0;
  int outstanding = 0;

  bmu_rr_scheduler #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .bmu_valid_in(bmu_valid_in), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in), .bmu_ap(bmu_ap),
    .bmu_result(bmu_result), .bmu_error(bmu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error)
`ifdef BMU_SCHED_ERRCNT_EN
    , .err_clr(err_clr), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural BMU: add flags signed overflow; gorc accepts only b==7 (orc.b).
  // With no valid input it registers junk, which the scheduler must ignore.
  always @(posedge clk) begin
    if (rst) begin
      bmu_result <= '0;
      bmu_error  <= 1'b0;
    end else if (bmu_valid_in) begin
      if (bmu_ap == OP_ADD) begin
        bmu_result <= bmu_a_in + bmu_b_in;
        bmu_error  <= (bmu_a_in[31] == bmu_b_in[31]) &&
                      ((bmu_a_in + bmu_b_in) >> 31 != {31'b0, bmu_a_in[31]});
      end else if (bmu_ap == OP_GORC && bmu_b_in == 32'd7) begin
        for (int k = 0; k < 4; k++)
          bmu_result[8*k +: 8] <= (|bmu_a_in[8*k +: 8]) ? 8'hFF : 8'h00;
        bmu_error <= 1'b0;
      end else begin
        bmu_result <= '0;
        bmu_error  <= 1'b1;
      end
    end else begin
      bmu_result <= 32'hDEADBEEF;
      bmu_error  <= 1'b1;
    end
  end

  // Accepted-but-not-popped ops must never exceed the queue depth.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      outstanding = outstanding + ((|(req_valid & req_ready)) ? 1 : 0)
                                - ((rsp_valid & rsp_ready) ? 1 : 0);
      checks++;
      if (outstanding > RSP_DEPTH || outstanding < 0) begin
        errors++;
        $display("FAIL overflow: outstanding=%0d limit=%0d at %0t", outstanding, RSP_DEPTH, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [OP_W-1:0] op);
    req_a[32*idx +: 32]     = a;
    req_b[32*idx +: 32]     = b;
    req_op[OP_W*idx +: OP_W] = op;
  endtask

  // Requester i adds 0x100*(i+1) and (i+1), so its result is 0x101*(i+1).
  task automatic set_fixed_ops();
    for (int i = 0; i < NUM_REQ; i++)
      set_op(i, 32'((i + 1) * 256), 32'(i + 1), OP_ADD);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
`ifdef BMU_SCHED_ERRCNT_EN
    err_clr   = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated op: grant in cycle 0, response visible in cycle 2, popped there.
  task automatic issue_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [OP_W-1:0] op, input logic [31:0] exp_res,
                           input logic exp_err, input logic clr);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    set_op(idx, a, b, op);
    req_valid = onehot;
    rsp_ready = 1'b1;
    #3;
    chk("issue_ready", 32'(req_ready), 32'(onehot));
    chk("issue_bmu_valid", 32'(bmu_valid_in), 32'd1);
    chk("issue_bmu_a", bmu_a_in, a);
    chk("issue_bmu_b", bmu_b_in, b);
    chk("issue_bmu_ap", 32'(bmu_ap), 32'(op));
    tick();
    req_valid = '0;
    #3;
    chk("lat1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_bmu_a", bmu_a_in, 32'd0);
    tick();
`ifdef BMU_SCHED_ERRCNT_EN
    err_clr = clr;
`endif
    #3;
    chk("lat2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat2_rsp_id", 32'(rsp_id), 32'(idx));
    chk("lat2_rsp_result", rsp_result, exp_res);
    chk("lat2_rsp_error", 32'(rsp_error), 32'(exp_err));
    tick();
`ifdef BMU_SCHED_ERRCNT_EN
    err_clr = 1'b0;
`endif
    #3;
    chk("after_pop_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    if (clr) chk("clr_unused", 32'd0, 32'd0 + 32'(clr & 1'b0));
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic        rrdy;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t tbl[23];

  initial begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;

    // Credits are only returned on the edge after a pop, so with two entries
    // continuous traffic pauses every third cycle; grant order stays 0,1,2,3.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h000, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 32'h000, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h101, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h202, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0, 32'h000, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, 32'h303, 1'b0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h404, 1'b0};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 32'h000, 1'b0};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h101, 1'b0};
    // Back-pressure: head must hold while the queue fills and grants stop.
    tbl[9]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd1, 32'h202, 1'b0};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h202, 1'b0};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h202, 1'b0};
    tbl[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h202, 1'b0};
    tbl[13] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h202, 1'b0};
    tbl[14] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h303, 1'b0};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h000, 1'b0};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h404, 1'b0};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h000, 1'b0};
    // Search wraps past the end: pointer at 2 picks requester 0.
    tbl[18] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 32'h000, 1'b0};
    tbl[19] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h000, 1'b0};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h202, 1'b0};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h101, 1'b0};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h000, 1'b0};

    // Reset state.
    do_reset();
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_bmu_valid", 32'(bmu_valid_in), 32'd0);
    chk("rst_bmu_a", bmu_a_in, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
`ifdef BMU_SCHED_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
    tick();

    // Single op 5+7.
    issue_one(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 1'b0);

    // Cycle-by-cycle vectors from a fresh reset.
    do_reset();
    set_fixed_ops();
    for (int i = 0; i < 23; i++) begin
      req_valid = tbl[i].valid;
      rsp_ready = tbl[i].rrdy;
      #3;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].exp_id));
      chk($sformatf("tbl%0d_rsp_result", i), rsp_result, tbl[i].exp_res);
      chk($sformatf("tbl%0d_rsp_error", i), 32'(rsp_error), 32'(tbl[i].exp_err));
      tick();
    end

    // Error results.
    issue_one(2, 32'h7FFFFFFF, 32'd1, OP_ADD, 32'h80000000, 1'b1, 1'b0);
    issue_one(3, 32'h12345678, 32'd3, OP_GORC, 32'h00000000, 1'b1, 1'b0);
    issue_one(1, 32'h00120300, 32'd7, OP_GORC, 32'h00FFFF00, 1'b0, 1'b0);
`ifdef BMU_SCHED_ERRCNT_EN
    chk("errcnt_two", 32'(err_count), 32'd2);
`endif
    issue_one(0, 32'h80000000, 32'hFFFFFFFF, OP_ADD, 32'h7FFFFFFF, 1'b1, 1'b0);
`ifdef BMU_SCHED_ERRCNT_EN
    chk("errcnt_three", 32'(err_count), 32'd3);
`endif
    // Clear in the same cycle as another error pop: clear wins.
    issue_one(1, 32'h7FFFFFFF, 32'd1, OP_ADD, 32'h80000000, 1'b1, 1'b1);
`ifdef BMU_SCHED_ERRCNT_EN
    chk("errcnt_clr_wins", 32'(err_count), 32'd0);
`endif

    // Reset with one op in flight and one response queued.
    set_fixed_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #3;
    chk("rmo_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0100;
    #3;
    chk("rmo_grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("rmo_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmo_rsp_valid_async", 32'(rsp_valid), 32'd0);
    chk("rmo_rsp_result_async", rsp_result, 32'd0);
    tick();
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk($sformatf("rmo_quiet%0d", i), 32'(rsp_valid), 32'd0);
      tick();
    end
    req_valid = 4'b1111;
    #3;
    chk("rmo_rr_restart", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #3;
    chk("rmo_post_lat1", 32'(rsp_valid), 32'd0);
    tick();
    #3;
    chk("rmo_post_valid", 32'(rsp_valid), 32'd1);
    chk("rmo_post_id", 32'(rsp_id), 32'd0);
    chk("rmo_post_result", rsp_result, 32'h101);
    tick();
    #3;
    chk("rmo_post_drained", 32'(rsp_valid), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
